// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types and constants for the data-memory arbitration slice.
//   owner_e   : who is waiting on the read data returned by the memory next cycle
//   mem_req_t : one memory request bundle at the default data-memory widths,
//               shared with the datapath and the host loader
package dmem_pkg;

    localparam int DMEM_ADDR_W    = 11;
    localparam int DMEM_DATA_W    = 32;
    localparam int DMEM_BE_W      = DMEM_DATA_W / 8;
    localparam int STARVE_CNT_W   = 4;
    localparam logic [STARVE_CNT_W-1:0] STARVE_CNT_MAX = '1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [DMEM_BE_W-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/dmem_starve_ctr.sv
// dmem_starve_ctr
// Counts consecutive cycles in which the host asked for the memory and lost.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   clr        : host was granted or is not requesting, restart the count
//   inc        : host requested and was denied this cycle
//   ge_limit   : count has reached LIMIT, host must be forced through
module dmem_starve_ctr
    import dmem_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic ge_limit
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    // Clear wins over increment; the count sticks at its maximum so a long
    // wait can never wrap back below the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != STARVE_CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ge_limit = (cnt_q >= LIMIT_V);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port synchronous data memory between the core load/store
// unit (c_*) and the host/debug loader (h_*). The core has default priority;
// a host that has lost STARVE_LIMIT cycles in a row is forced through once.
// Read data (1-cycle memory latency) is routed back to whoever issued the read.
// Ports:
//   clk, reset                               : clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata/c_be           : core request bundle
//   c_gnt, c_rvalid, c_rdata, core_stall     : core grant, read response, stall
//   h_req/h_we/h_addr/h_wdata/h_be           : host request bundle
//   h_gnt, h_rvalid, h_rdata                 : host grant and read response
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be  : memory request, zero when idle
//   mem_rdata                                : memory read data, 1 cycle after a read
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                c_req,
    input  logic                c_we,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    input  logic [DATA_W/8-1:0] c_be,
    output logic                c_gnt,
    output logic                c_rvalid,
    output logic [DATA_W-1:0]   c_rdata,
    output logic                core_stall,

    input  logic                h_req,
    input  logic                h_we,
    input  logic [ADDR_W-1:0]   h_addr,
    input  logic [DATA_W-1:0]   h_wdata,
    input  logic [DATA_W/8-1:0] h_be,
    output logic                h_gnt,
    output logic                h_rvalid,
    output logic [DATA_W-1:0]   h_rdata,

    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    // Request bundle at this instance's widths (same layout as mem_req_t).
    typedef struct packed {
        logic                we;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [DATA_W/8-1:0] be;
    } req_t;

    req_t   c_bundle;
    req_t   h_bundle;
    req_t   mem_bundle;
    logic   host_forced;
    owner_e rd_owner_q;
    owner_e rd_owner_d;

    assign c_bundle = '{we: c_we, addr: c_addr, wdata: c_wdata, be: c_be};
    assign h_bundle = '{we: h_we, addr: h_addr, wdata: h_wdata, be: h_be};

    dmem_starve_ctr #(
        .LIMIT    (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .reset    (reset),
        .clr      (h_gnt | ~h_req),
        .inc      (h_req & ~h_gnt),
        .ge_limit (host_forced)
    );

    // Grants depend only on requests, reset and the registered starvation
    // flag, so there is no path from mem_rdata back into arbitration.
    always_comb begin
        c_gnt = 1'b0;
        h_gnt = 1'b0;
        if (!reset) begin
            if (h_req && host_forced) begin
                h_gnt = 1'b1;
            end else if (c_req) begin
                c_gnt = 1'b1;
            end else if (h_req) begin
                h_gnt = 1'b1;
            end
        end
    end

    // Memory side: forward the granted bundle, drive all zeros when idle.
    always_comb begin
        mem_bundle = '0;
        if (c_gnt) begin
            mem_bundle = c_bundle;
        end else if (h_gnt) begin
            mem_bundle = h_bundle;
        end
    end

    assign mem_en     = c_gnt | h_gnt;
    assign mem_we     = mem_bundle.we;
    assign mem_addr   = mem_bundle.addr;
    assign mem_wdata  = mem_bundle.wdata;
    assign mem_be     = mem_bundle.be;
    assign core_stall = c_req & ~c_gnt & ~reset;

    // Remember who owns the data coming back next cycle; writes own nothing.
    always_comb begin
        rd_owner_d = OWN_NONE;
        if (c_gnt && !c_we) begin
            rd_owner_d = OWN_CORE;
        end else if (h_gnt && !h_we) begin
            rd_owner_d = OWN_HOST;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    // Reset also masks a response already in flight when it asserts.
    always_comb begin
        c_rvalid = 1'b0;
        h_rvalid = 1'b0;
        c_rdata  = '0;
        h_rdata  = '0;
        if (!reset) begin
            if (rd_owner_q == OWN_CORE) begin
                c_rvalid = 1'b1;
                c_rdata  = mem_rdata;
            end else if (rd_owner_q == OWN_HOST) begin
                h_rvalid = 1'b1;
                h_rdata  = mem_rdata;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory of the 3-stage RISC-V pipeline between two requesters: the core load/store unit (port c_) and a host/debug loader port (port h_).
- Core has default priority; a starvation counter forces a host grant after STARVE_LIMIT consecutive lost cycles.
- Memory is synchronous with 1-cycle read latency. The arbiter routes read data back to whichever requester issued the read.
- Emits core_stall for the pipeline hazard logic.

Parameters:
- ADDR_W, 11, byte address width (covers the 0x000-0x7FF data space; stack top 0x400).
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive host-denied cycles before the host gets forced priority; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- c_req  in  1  core access request.
- c_we  in  1  core write enable (0 = read).
- c_addr  in  ADDR_W  core byte address.
- c_wdata  in  DATA_W  core write data.
- c_be  in  DATA_W/8  core byte enables.
- c_gnt  out  1  core request accepted this cycle.
- c_rvalid  out  1  core read data valid.
- c_rdata  out  DATA_W  core read data.
- core_stall  out  1  equals c_req & ~c_gnt.
- h_req, h_we, h_addr, h_wdata, h_be  in  same widths as the c_ inputs  host request bundle.
- h_gnt  out  1  host request accepted this cycle.
- h_rvalid  out  1  host read data valid.
- h_rdata  out  DATA_W  host read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a read with mem_en=1.

Behaviour:
- Grant is combinational, in the same cycle as req. A request is accepted only when req=1 and gnt=1 in the same cycle.
- A requester holds its request fields stable while req=1 and gnt=0.
- At most one grant per cycle. mem_en = c_gnt | h_gnt. The mem_* fields mux from the granted requester; when idle they are 0.
- Arbitration priority:
  - If reset=1, no grants.
  - Else if h_req and starve_cnt >= STARVE_LIMIT, grant the host.
  - Else if c_req, grant the core.
  - Else if h_req, grant the host.
- starve_cnt (4-bit, registered):
  - Cleared on reset.
  - Cleared on any h_gnt or when h_req=0.
  - Incremented when h_req=1 and h_gnt=0.
  - Saturates at 15.
- Read response:
  - A registered owner flag rd_owner ∈ {NONE, CORE, HOST} is set when a read (gnt & ~we) is accepted, else NONE.
  - In the next cycle, the owner's rvalid=1 and its rdata=mem_rdata. The other requester's rdata is 0.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating owners are legal: each response follows its own issue by exactly 1 cycle.
- Reset, synchronous:
  - starve_cnt=0, rd_owner=NONE.
  - c_rvalid=h_rvalid=0, c_gnt=h_gnt=0, mem_en=0, core_stall=0, rdata outputs 0.
  - A read issued in the cycle reset asserts produces no rvalid.
  - A read in flight when reset asserts is dropped: no rvalid.
- Simultaneous c_req and h_req with starve_cnt < STARVE_LIMIT: core wins, host waits, counter increments.
- Once the host is granted by the forced path, the next cycle reverts to core priority.
- No combinational path from mem_rdata to any gnt.

Decomposition:
- Package dmem_pkg:
  - typedef owner_e {OWN_NONE, OWN_CORE, OWN_HOST}.
  - Struct mem_req_t {we, addr, wdata, be}, reused by the datapath and loader.
  - Constant DMEM_ADDR_W=11.
- One natural sub-module, dmem_starve_ctr: saturating counter with clear/inc and a ge_limit flag.
- The grant mux and response routing stay in the top block.

Test Plan:
- Reset held 2 cycles with c_req=h_req=1 -> all gnt=0, mem_en=0, rvalid=0. First cycle after release -> c_gnt=1, h_gnt=0.
- Core read addr 0x3E0 (memory preloaded 0x5), no host -> c_gnt same cycle, mem_addr=0x3E0, mem_we=0. Next cycle c_rvalid=1, c_rdata=0x5, h_rvalid=0.
- Host write 0xA to 0x3DC while core idle -> h_gnt=1, mem_we=1, mem_be=4'hF, no rvalid. Subsequent core read of 0x3DC returns 0xA.
- c_req and h_req held continuously, STARVE_LIMIT=4 -> grant pattern C,C,C,C,H,C,C,C,C,H. core_stall=1 exactly in the H cycles.
- Alternating reads: core reads 0x3E0, then host reads 0x3DC on the next cycle -> c_rvalid the cycle after the core issue, h_rvalid the cycle after that, data 0x5 then 0xA, no crossover.
- Reset asserted the cycle after a core read issue -> c_rvalid stays 0, starve_cnt=0, and normal arbitration resumes after release.
